// File: rtl/switch_debouncer_multi_if.sv
// Signal bundle between the board slide switches and the debouncer:
// raw levels in, accepted levels and one-clock change strobes out.
interface switch_debouncer_multi_if #(
    parameter int N_CHANNELS = 4
) ();
    logic [N_CHANNELS-1:0] i_switches_raw;
    logic [N_CHANNELS-1:0] o_switches_debounced;
    logic [N_CHANNELS-1:0] o_switches_rise;
    logic [N_CHANNELS-1:0] o_switches_fall;
    logic                  o_switches_changed;

    // master is the switch side, slave is the debouncer itself
    modport master (
        output i_switches_raw,
        input  o_switches_debounced,
        input  o_switches_rise,
        input  o_switches_fall,
        input  o_switches_changed
    );

    modport slave (
        input  i_switches_raw,
        output o_switches_debounced,
        output o_switches_rise,
        output o_switches_fall,
        output o_switches_changed
    );
endinterface

// File: rtl/switch_debouncer_multi.sv
// Per-channel two-flop synchronizer plus debounce FSM; a new switch level is
// accepted after STABLE_CYCLES consecutive differing clocks, with edge strobes.
module switch_debouncer_multi #(
    parameter int N_CHANNELS    = 4,
    parameter int STABLE_CYCLES = 20000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic                    i_clk_20mhz,
    input  logic                    i_rstn_20mhz,
    switch_debouncer_multi_if.slave sw_if
);
    typedef enum logic {ST_STABLE, ST_PENDING} state_e;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(STABLE_CYCLES - 1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    logic [N_CHANNELS-1:0] sync1_q, sync2_q;
    logic [N_CHANNELS-1:0] deb_q, deb_d;
    logic [N_CHANNELS-1:0] rise_q, rise_d;
    logic [N_CHANNELS-1:0] fall_q, fall_d;
    logic                  changed_q;
    state_e                state_q [N_CHANNELS];
    state_e                state_d [N_CHANNELS];
    cnt_t                  cnt_q   [N_CHANNELS];
    cnt_t                  cnt_d   [N_CHANNELS];

    always_comb begin
        // NOTE: every _d signal gets a default before the case, so no path can infer a latch.
        deb_d   = deb_q;
        rise_d  = '0;
        fall_d  = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int ch = 0; ch < N_CHANNELS; ch++) begin
            case (state_q[ch])
                ST_STABLE: begin
                    if (sync2_q[ch] != deb_q[ch]) begin
                        cnt_d[ch]   = CNT_ONE;
                        state_d[ch] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (sync2_q[ch] == deb_q[ch]) begin
                        cnt_d[ch]   = '0;
                        state_d[ch] = ST_STABLE;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        // Counter is cleared on acceptance, so it never needs to wrap.
                        deb_d[ch]   = sync2_q[ch];
                        rise_d[ch]  = sync2_q[ch];
                        fall_d[ch]  = ~sync2_q[ch];
                        cnt_d[ch]   = '0;
                        state_d[ch] = ST_STABLE;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d[ch]   = '0;
                    state_d[ch] = ST_STABLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they take the async reset too.
            for (int ch = 0; ch < N_CHANNELS; ch++) begin
                state_q[ch] <= ST_STABLE;
                cnt_q[ch]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep sync2_q one clock behind sync1_q.
            sync1_q   <= sw_if.i_switches_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_if.o_switches_debounced = deb_q;
    assign sw_if.o_switches_rise      = rise_q;
    assign sw_if.o_switches_fall      = fall_q;
    assign sw_if.o_switches_changed   = changed_q;
endmodule

// File: tb/tb_switch_debouncer_multi.sv
// Bench for switch_debouncer_multi: table-driven per-edge vectors through a
// scoreboard queue on a STABLE_CYCLES=4 instance, plus a full-size 20000 instance.
module tb_switch_debouncer_multi;
    localparam int NCH      = 4;
    localparam int SC_SHORT = 4;
    localparam int SC_LONG  = 20000;

    typedef struct {
        logic [NCH-1:0] raw;
        logic [NCH-1:0] deb;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic           chg;
    } vec_t;

    logic i_clk_20mhz  = 1'b0;
    logic i_rstn_20mhz = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    switch_debouncer_multi_if #(.N_CHANNELS(NCH)) sw_if ();
    switch_debouncer_multi_if #(.N_CHANNELS(NCH)) lsw_if ();

    switch_debouncer_multi #(
        .N_CHANNELS(NCH), .STABLE_CYCLES(SC_SHORT), .CNT_WIDTH(20)
    ) dut (
        .i_clk_20mhz (i_clk_20mhz),
        .i_rstn_20mhz(i_rstn_20mhz),
        .sw_if       (sw_if)
    );

    switch_debouncer_multi #(
        .N_CHANNELS(NCH), .STABLE_CYCLES(SC_LONG), .CNT_WIDTH(20)
    ) dut_long (
        .i_clk_20mhz (i_clk_20mhz),
        .i_rstn_20mhz(i_rstn_20mhz),
        .sw_if       (lsw_if)
    );

    always #25 i_clk_20mhz = ~i_clk_20mhz;

    task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic [NCH-1:0] raw, input logic [NCH-1:0] deb,
                                input logic [NCH-1:0] rise, input logic [NCH-1:0] fall,
                                input logic chg);
        vec_t v;
        v.raw  = raw;
        v.deb  = deb;
        v.rise = rise;
        v.fall = fall;
        v.chg  = chg;
        tbl.push_back(v);
    endfunction

    // Raw held from edge 1: quiet through edge SC+1, accepted on edge SC+2, quiet after.
    function automatic void add_step(input logic [NCH-1:0] raw, input logic [NCH-1:0] old_deb,
                                     input logic [NCH-1:0] new_deb);
        for (int e = 1; e <= SC_SHORT + 1; e++) add(raw, old_deb, '0, '0, 1'b0);
        add(raw, new_deb, new_deb & ~old_deb, old_deb & ~new_deb, 1'b1);
        add(raw, new_deb, '0, '0, 1'b0);
    endfunction

    task automatic cycle(input vec_t v, input string tag);
        vec_t e;
        sw_if.i_switches_raw = v.raw;
        exp_q.push_back(v);
        @(posedge i_clk_20mhz);
        #1;
        e = exp_q.pop_front();
        check({tag, " deb"},  sw_if.o_switches_debounced, e.deb);
        check({tag, " rise"}, sw_if.o_switches_rise,      e.rise);
        check({tag, " fall"}, sw_if.o_switches_fall,      e.fall);
        check({tag, " chg"},  NCH'(sw_if.o_switches_changed), NCH'(e.chg));
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) cycle(tbl[i], $sformatf("vec%0d", i));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " deb"},  sw_if.o_switches_debounced, '0);
        check({tag, " rise"}, sw_if.o_switches_rise,      '0);
        check({tag, " fall"}, sw_if.o_switches_fall,      '0);
        check({tag, " chg"},  NCH'(sw_if.o_switches_changed), '0);
    endtask

    initial begin
        int   seg_a_end;
        int   viol;
        vec_t v;

        sw_if.i_switches_raw  = 4'b0101;
        lsw_if.i_switches_raw = '0;

        // Segment A: reset release with 0101, clean rise, fall, bounce, simultaneous swap.
        add_step(4'b0101, 4'b0000, 4'b0101);
        add_step(4'b0111, 4'b0101, 4'b0111);
        add_step(4'b0110, 4'b0111, 4'b0110);
        add(4'b0111, 4'b0110, '0, '0, 1'b0);
        add(4'b0110, 4'b0110, '0, '0, 1'b0);
        add(4'b0111, 4'b0110, '0, '0, 1'b0);
        add(4'b0111, 4'b0110, '0, '0, 1'b0);
        add(4'b0110, 4'b0110, '0, '0, 1'b0);
        for (int e = 6; e <= 10; e++) add(4'b0111, 4'b0110, '0, '0, 1'b0);
        add(4'b0111, 4'b0111, 4'b0001, 4'b0000, 1'b1);
        add(4'b0111, 4'b0111, '0, '0, 1'b0);
        add_step(4'b0011, 4'b0111, 4'b0011);
        add_step(4'b1100, 4'b0011, 4'b1100);
        seg_a_end = tbl.size();
        // Segment B: after a mid-pending reset, full latency is needed again.
        add_step(4'b1000, 4'b0000, 4'b1000);

        #5 i_rstn_20mhz = 1'b0;
        #5;
        check_zero("rst_async");
        check("rst_async long deb", lsw_if.o_switches_debounced, '0);
        repeat (2) @(posedge i_clk_20mhz);
        #1;
        check_zero("rst_held");
        @(negedge i_clk_20mhz);
        i_rstn_20mhz = 1'b1;

        run_table(0, seg_a_end);

        // Channel 2 goes pending and reaches count 3 without being accepted.
        for (int e = 1; e <= SC_SHORT + 1; e++) begin
            v.raw  = 4'b1000;
            v.deb  = 4'b1100;
            v.rise = '0;
            v.fall = '0;
            v.chg  = 1'b0;
            cycle(v, $sformatf("pend%0d", e));
        end
        #10 i_rstn_20mhz = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (2) @(posedge i_clk_20mhz);
        #1;
        check_zero("rst_mid_held");
        @(negedge i_clk_20mhz);
        i_rstn_20mhz = 1'b1;

        run_table(seg_a_end, tbl.size());

        // Full-size instance: a 999 us pulse is rejected.
        viol = 0;
        for (int e = 1; e <= 19980 + 10; e++) begin
            lsw_if.i_switches_raw = (e <= 19980) ? 4'b1000 : 4'b0000;
            @(posedge i_clk_20mhz);
            #1;
            if (lsw_if.o_switches_debounced !== 4'b0000 || lsw_if.o_switches_changed !== 1'b0) viol++;
        end
        check_int("long_reject changes", viol, 0);

        // A level held long enough is accepted exactly on edge 20002.
        viol = 0;
        for (int e = 1; e <= SC_LONG + 3; e++) begin
            lsw_if.i_switches_raw = 4'b1000;
            @(posedge i_clk_20mhz);
            #1;
            if (e <= SC_LONG + 1) begin
                if (lsw_if.o_switches_debounced !== 4'b0000 || lsw_if.o_switches_changed !== 1'b0) viol++;
            end
            if (e == SC_LONG + 1) check("long e20001 deb", lsw_if.o_switches_debounced, 4'b0000);
            if (e == SC_LONG + 2) begin
                check("long e20002 deb",  lsw_if.o_switches_debounced, 4'b1000);
                check("long e20002 rise", lsw_if.o_switches_rise,      4'b1000);
                check("long e20002 fall", lsw_if.o_switches_fall,      4'b0000);
                check("long e20002 chg",  NCH'(lsw_if.o_switches_changed), 4'b0001);
            end
            if (e == SC_LONG + 3) begin
                check("long e20003 deb",  lsw_if.o_switches_debounced, 4'b1000);
                check("long e20003 rise", lsw_if.o_switches_rise,      4'b0000);
                check("long e20003 chg",  NCH'(lsw_if.o_switches_changed), 4'b0000);
            end
        end
        check_int("long_accept early changes", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
